// File: rtl/if_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : if_fetch_stage
// Brief  : Instruction fetch with PC/nPC delayed-branch update and skid buffer
// Rev    : 1.0  initial release
// ============================================================================
module if_fetch_stage #(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    input  logic              id_stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    output logic [31:0]       pc,
    output logic [31:0]       npc,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic              if_id_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, npc_q, npc_d;
    logic [31:0] instr_q, idpc_q;
    logic        valid_q;
    logic [31:0] skid_instr_q, skid_pc_q;
    logic        skid_full_q;
    logic        pend_q;
    logic [31:0] pend_target_q;

    logic        advance, capture, bubble;
    logic        from_skid;
    logic [31:0] adv_instr, adv_pc;
    logic [31:0] redir_target;
    logic        take_redir;
    logic [31:0] take_target;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        capture = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_ack) begin
                    if (!id_stall) begin
                        advance = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (!id_stall) begin
                    bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    advance = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign from_skid = (state_q == S_HOLD) && skid_full_q;
    assign adv_instr = from_skid ? skid_instr_q : imem_data;
    assign adv_pc    = from_skid ? skid_pc_q    : pc_q;

    // A same-cycle redirect is newer than any pending one, so it wins.
    assign redir_target = redirect_target & ~32'h3;
    assign take_redir   = redirect | pend_q;
    assign take_target  = redirect ? redir_target : pend_target_q;

    always_comb begin
        pc_d  = pc_q;
        npc_d = npc_q;
        if (advance) begin
            pc_d  = npc_q;
            npc_d = take_redir ? take_target : npc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            npc_q         <= RESET_PC + 32'd4;
            instr_q       <= 32'h0;
            idpc_q        <= 32'h0;
            valid_q       <= 1'b0;
            skid_instr_q  <= 32'h0;
            skid_pc_q     <= 32'h0;
            skid_full_q   <= 1'b0;
            pend_q        <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;

            if (advance) begin
                instr_q <= adv_instr;
                idpc_q  <= adv_pc;
                valid_q <= 1'b1;
            end else if (bubble) begin
                valid_q <= 1'b0;
            end

            if (capture) begin
                skid_instr_q <= imem_data;
                skid_pc_q    <= pc_q;
                skid_full_q  <= 1'b1;
            end else if (advance) begin
                skid_full_q  <= 1'b0;
            end

            if (advance) begin
                pend_q <= 1'b0;
            end else if (redirect) begin
                pend_q        <= 1'b1;
                pend_target_q <= redir_target;
            end
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q[ADDR_W-1:0];
    assign pc          = pc_q;
    assign npc         = npc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = idpc_q;
    assign if_id_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_if_fetch_stage
// Brief  : Directed-vector bench for if_fetch_stage with a byte memory model
// Rev    : 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc, npc, if_id_instr, if_id_pc;
    logic        if_id_valid;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [512];

    if_fetch_stage #(.ADDR_W(9), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .id_stall(id_stall), .redirect(redirect),
        .redirect_target(redirect_target),
        .pc(pc), .npc(npc),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [8:0] a);
        return {mem[a], mem[a + 9'd1], mem[a + 9'd2], mem[a + 9'd3]};
    endfunction

    always_comb imem_data = word_at(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        mem[a]   = w[31:24];
        mem[a+1] = w[23:16];
        mem[a+2] = w[15:8];
        mem[a+3] = w[7:0];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
        put_word(0, 32'h24050000);
        put_word(4, 32'h24060001);
        put_word(8, 32'h00A63023);

        reset = 1'b1; imem_ack = 1'b1; id_stall = 1'b0;
        redirect = 1'b0; redirect_target = 32'h0;
        step(); step();
        check("rst_pc",    pc, 32'h0);
        check("rst_npc",   npc, 32'h4);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_req",   {31'h0, imem_req}, 32'h0);
        reset = 1'b0;
        check("idle_req",  {31'h0, imem_req}, 32'h0);

        // IDLE -> REQ, then one instruction per cycle
        step();
        check("req_up",    {31'h0, imem_req}, 32'h1);
        check("req_addr",  {23'h0, imem_addr}, 32'h0);
        check("req_valid", {31'h0, if_id_valid}, 32'h0);
        step();
        check("f0_instr", if_id_instr, 32'h24050000);
        check("f0_pc",    if_id_pc, 32'h0);
        check("f0_valid", {31'h0, if_id_valid}, 32'h1);
        check("f0_npc",   npc, 32'h8);
        step();
        check("f1_instr", if_id_instr, 32'h24060001);
        check("f1_pc",    if_id_pc, 32'h4);
        check("f1_npc",   npc, 32'hC);

        // Redirect while the word at pc 8 enters IF/ID: delay slot 12, then 0x40
        redirect = 1'b1; redirect_target = 32'h40;
        step();
        redirect = 1'b0;
        check("f2_instr", if_id_instr, 32'h00A63023);
        check("f2_pc",    if_id_pc, 32'h8);
        check("br_pc",    pc, 32'hC);
        check("br_npc",   npc, 32'h40);
        step();
        check("ds_idpc",  if_id_pc, 32'hC);
        check("tgt_pc",   pc, 32'h40);
        step();
        check("tgt_idpc", if_id_pc, 32'h40);
        check("tgt_ins",  if_id_instr, word_at(9'h040));
        redirect = 1'b1; redirect_target = 32'h41;
        step();
        redirect = 1'b0;
        check("mask_npc", npc, 32'h40);
        check("mask_pc",  pc, 32'h48);
        step();
        check("mask_idpc", if_id_pc, 32'h48);
        check("mask_pc2",  pc, 32'h40);

        // Stall with ack: capture into skid buffer, hold 3 cycles
        id_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_req",  {31'h0, imem_req}, 32'h0);
            check("hold_idpc", if_id_pc, 32'h48);
            check("hold_ins",  if_id_instr, word_at(9'h048));
            check("hold_pc",   pc, 32'h40);
        end
        id_stall = 1'b0;
        step();
        check("rel_ins",   if_id_instr, word_at(9'h040));
        check("rel_idpc",  if_id_pc, 32'h40);
        check("rel_valid", {31'h0, if_id_valid}, 32'h1);
        check("rel_addr",  {23'h0, imem_addr}, 32'h044);
        check("rel_req",   {31'h0, imem_req}, 32'h1);
        step();
        check("rel_next",  if_id_pc, 32'h44);

        // ack=0 with stall: IF/ID holds valid, request stays up
        imem_ack = 1'b0; id_stall = 1'b1;
        step();
        check("ws_stall_v",   {31'h0, if_id_valid}, 32'h1);
        check("ws_stall_req", {31'h0, imem_req}, 32'h1);
        id_stall = 1'b0;

        // Two wait states, redirect to 0x100 arriving during a wait
        redirect = 1'b1; redirect_target = 32'h100;
        step();
        redirect = 1'b0;
        check("ws_v0", {31'h0, if_id_valid}, 32'h0);
        step();
        check("ws_v1", {31'h0, if_id_valid}, 32'h0);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("ws_v2",   {31'h0, if_id_valid}, 32'h1);
        check("ws_idpc", if_id_pc, 32'h48);
        check("ws_npc",  npc, 32'h100);
        step();
        check("ws_v3", {31'h0, if_id_valid}, 32'h0);
        step();
        check("ws_v4", {31'h0, if_id_valid}, 32'h0);
        imem_ack = 1'b1;
        step();
        check("ws_v5",    {31'h0, if_id_valid}, 32'h1);
        check("ws_idpc2", if_id_pc, 32'h4C);
        check("ws_pc",    pc, 32'h100);

        // Address wrap within the 512-byte memory
        redirect = 1'b1; redirect_target = 32'h1FC;
        step();
        redirect = 1'b0;
        step();
        check("wr_addr0", {23'h0, imem_addr}, 32'h1FC);
        step();
        check("wr_pc",    pc, 32'h200);
        check("wr_addr1", {23'h0, imem_addr}, 32'h000);
        step();
        check("wr_idpc",  if_id_pc, 32'h200);
        check("wr_ins",   if_id_instr, 32'h24050000);

        // npc wraps modulo 2^32
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("nw_npc0", npc, 32'hFFFF_FFFC);
        step();
        check("nw_pc",   pc, 32'hFFFF_FFFC);
        check("nw_npc1", npc, 32'h0);

        // Reset while in HOLD; ack in the following cycle is ignored
        id_stall = 1'b1;
        step();
        check("rh_hold", {31'h0, imem_req}, 32'h0);
        reset = 1'b1;
        #1;
        check("rh_pc",    pc, 32'h0);
        check("rh_npc",   npc, 32'h4);
        check("rh_valid", {31'h0, if_id_valid}, 32'h0);
        check("rh_idpc",  if_id_pc, 32'h0);
        check("rh_req",   {31'h0, imem_req}, 32'h0);
        step();
        reset = 1'b0; id_stall = 1'b0; imem_ack = 1'b1;
        step();
        check("rh_ign_v",  {31'h0, if_id_valid}, 32'h0);
        check("rh_ign_pc", pc, 32'h0);
        check("rh_req2",   {31'h0, imem_req}, 32'h1);
        step();
        check("rh_f0_ins", if_id_instr, 32'h24050000);
        check("rh_f0_pc",  if_id_pc, 32'h0);
        check("rh_f0_v",   {31'h0, if_id_valid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch (IF) stage feeding the IF/ID pipeline register consumed by the ID stage and control unit.
- Keeps the architectural PC/nPC pair with delayed-branch semantics: the instruction after a taken transfer (the delay slot) always executes.
- Issues requests to the byte-addressed instruction memory through a req/ack handshake with variable latency.
- Honours ID-stage stalls through a one-entry skid buffer.

Parameters:
- ADDR_W, 9, instruction-memory byte-address width (512-byte memory).
- RESET_PC, 32'h0, PC value after reset; nPC resets to RESET_PC+4.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  ADDR_W  fetch byte address, equal to pc[ADDR_W-1:0].
- imem_ack  input  1  imem_data valid this cycle; only meaningful while imem_req=1.
- imem_data  input  32  big-endian word {Mem[a],Mem[a+1],Mem[a+2],Mem[a+3]}.
- id_stall  input  1  ID stage cannot accept; IF/ID register must hold.
- redirect  input  1  one-cycle pulse: taken branch or jump resolved in ID.
- redirect_target  input  32  transfer target; bits [1:0] are forced to 00.
- pc  output  32  current fetch PC.
- npc  output  32  next PC.
- if_id_instr  output  32  IF/ID instruction register.
- if_id_pc  output  32  PC of if_id_instr.
- if_id_valid  output  1  if_id_instr is real; 0 means bubble (NOP).

Behaviour:
- Reset values (asynchronous, immediate): pc=RESET_PC, npc=RESET_PC+4, if_id_instr=0, if_id_pc=0, if_id_valid=0, imem_req=0, skid buffer empty, pending_redirect=0, state=IDLE.
- States: IDLE, REQ, HOLD.
- IDLE: imem_req=0. Moves to REQ on the next clock unconditionally.
- REQ: imem_req=1, imem_addr=pc[ADDR_W-1:0].
  - ack=1, id_stall=0 ("advance"): if_id_instr<=imem_data, if_id_pc<=pc, if_id_valid<=1, PC update applied; stay in REQ.
  - ack=1, id_stall=1: imem_data and pc go into the skid buffer; IF/ID holds; PC does not update; go to HOLD.
  - ack=0, id_stall=0: if_id_valid<=0 (bubble inserted); stay in REQ.
  - ack=0, id_stall=1: IF/ID holds; stay in REQ.
- HOLD: imem_req=0.
  - id_stall=1: everything holds.
  - id_stall=0: load the skid buffer into IF/ID with if_id_valid<=1, apply the PC update, empty the buffer, go to REQ.
- PC update, applied only on an advance:
  - Normal: pc<=npc, npc<=npc+4.
  - Redirect taken (redirect this cycle, or pending_redirect=1): pc<=npc (delay slot), npc<=target, pending_redirect<=0.
- redirect arriving in a cycle without an advance: target latched into pending_redirect/pending_target and applied at the next advance.
- A second redirect while one is pending overwrites it; the latest target wins.
- Latency: a 0-wait-state memory gives one instruction per cycle. imem_req asserts one cycle after reset release, and the first if_id_valid=1 appears on the clock edge that samples the first ack.
- Arithmetic: npc+4 wraps modulo 2^32. imem_addr is pc truncated to ADDR_W bits, so fetches wrap within memory. If_id_pc keeps the full 32 bits.
- No flush: delay-slot semantics mean no fetched instruction is ever discarded.
- Reset mid-request: the outstanding request is abandoned and an imem_ack in the following cycles is ignored (the stage is in IDLE with imem_req=0). The memory must tolerate an abandoned request.
- Outputs pc and npc are registered; imem_req and imem_addr are derived from state and pc only, never combinationally from imem_ack.

Test Plan:
- Reset, memory always ack, words 0x24050000, 0x24060001, 0x00A63023 at 0/4/8 -> IF/ID shows them on consecutive cycles; if_id_pc = 0, 4, 8; npc = 4, 8, 12, 16.
- redirect pulse with target 0x40 (then 0x41) while ID holds the instruction at pc 8 -> next fetches are pc 12 (delay slot), then 0x40; 0x41 is forced to 0x40.
- id_stall high 3 cycles while ack arrives for pc 16 -> HOLD entered, imem_req=0, IF/ID unchanged; stall release -> IF/ID = word@16, if_id_pc=16, then fetch pc 20.
- Memory with 2 wait states -> if_id_valid = 1,0,0,1,0,0 pattern; redirect asserted during a wait is applied at the next advance.
- pc=0x1FC, ADDR_W=9 -> next imem_addr=0x000 with pc=0x200, if_id_pc=0x200; npc=0xFFFFFFFC advances to 0x0.
- Assert reset while in HOLD, with ack asserted next cycle -> all outputs return to reset values, ack ignored, fetch restarts at RESET_PC.
